// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Holds the fetch response payload and the default memory base address.
package imem_responder_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t addr;
        word_t instr;
        logic  err;
    } imem_rsp_t;

    localparam word_t BaseAddress = 32'h8000_0000;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Two-entry response queue for the instruction-memory responder.
// Outputs zero on the head when empty so the response bus idles at zero.
module imem_rsp_fifo
    import imem_responder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  imem_rsp_t  push_data,
    input  logic       pop,
    output imem_rsp_t  head,
    output logic [1:0] count,
    output logic       full,
    output logic       empty
);

    imem_rsp_t entries [2];
    logic      rd_ptr;
    logic      wr_ptr;
    logic      do_push;
    logic      do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : entries[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            entries[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Memory-side responder for instruction fetch: byte array, word reads with
// one cycle of latency through a two-entry queue, and a byte load port.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int    SizeBytes   = 4096,
    parameter word_t BaseAddress = imem_responder_pkg::BaseAddress,
    parameter string InitPath    = ""
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_addr_o,
    output logic [31:0] rsp_instr_o,
    output logic        rsp_err_o,
    input  logic        load_valid_i,
    input  logic [31:0] load_addr_i,
    input  logic [7:0]  load_data_i,
    output logic        load_err_o
);

    localparam int    AW       = $clog2(SizeBytes);
    localparam word_t LastWord = word_t'(SizeBytes - 4);
    localparam word_t SizeWord = word_t'(SizeBytes);

    if ((SizeBytes < 4) || ((SizeBytes % 4) != 0)) begin : g_bad_size
        $error("imem_responder: SizeBytes must be a multiple of 4 and at least 4");
    end

    logic [7:0] mem [SizeBytes];

    word_t           req_off;
    logic            req_err;
    logic [AW-1:0]   req_idx;
    word_t           rd_word;
    word_t           load_off;
    logic            load_ok;
    logic [AW-1:0]   load_idx;
    logic            push;
    logic            pop;
    imem_rsp_t       push_data;
    imem_rsp_t       head;
    logic [1:0]      count;
    logic            full;
    logic            empty;

    // Errored fetches read byte 0 so the array is never indexed out of range.
    always_comb begin
        req_off = req_addr_i - BaseAddress;
        req_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i < BaseAddress) ||
                  (req_off > LastWord);
        req_idx = req_err ? '0 : req_off[AW-1:0];
        rd_word = {mem[req_idx + AW'(3)], mem[req_idx + AW'(2)],
                   mem[req_idx + AW'(1)], mem[req_idx]};
    end

    always_comb begin
        load_off = load_addr_i - BaseAddress;
        load_ok  = (load_addr_i >= BaseAddress) && (load_off < SizeWord);
        load_idx = load_ok ? load_off[AW-1:0] : '0;
    end

    assign req_ready_o     = !full;
    assign push            = req_valid_i && req_ready_o && !rst_i;
    assign pop             = rsp_valid_o && rsp_ready_i;
    assign push_data.addr  = req_addr_i;
    assign push_data.instr = req_err ? '0 : rd_word;
    assign push_data.err   = req_err;

    imem_rsp_fifo u_rsp_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign rsp_valid_o = !empty;
    assign rsp_addr_o  = head.addr;
    assign rsp_instr_o = head.instr;
    assign rsp_err_o   = head.err;

    // Reads above see the pre-edge contents, giving read-before-write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && load_valid_i && load_ok) begin
            mem[load_idx] <= load_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            load_err_o <= 1'b0;
        end else begin
            load_err_o <= load_valid_i && !load_ok;
        end
    end

`ifndef NDEBUG
    property p_rsp_hold;
        @(posedge clk_i) (rsp_valid_o && !rsp_ready_i && !rst_i) |=>
            (rsp_valid_o && $stable(rsp_addr_o) && $stable(rsp_instr_o) &&
             $stable(rsp_err_o));
    endproperty
    a_rsp_hold: assert property (p_rsp_hold);
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: 16-byte array at 0x8000_0000 filled
// with bytes 00..0F through the load port, then fetch/backpressure/error/reset cases.
module tb_imem_responder;

    localparam logic [31:0] Base = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_addr_o;
    logic [31:0] rsp_instr_o;
    logic        rsp_err_o;
    logic        load_valid_i;
    logic [31:0] load_addr_i;
    logic [7:0]  load_data_i;
    logic        load_err_o;

    int assertions = 0;
    int failures   = 0;

    imem_responder #(
        .SizeBytes   (16),
        .BaseAddress (Base),
        .InitPath    ("")
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_addr_o   (rsp_addr_o),
        .rsp_instr_o  (rsp_instr_o),
        .rsp_err_o    (rsp_err_o),
        .load_valid_i (load_valid_i),
        .load_addr_i  (load_addr_i),
        .load_data_i  (load_data_i),
        .load_err_o   (load_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        assertions++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] addr,
                             input logic [31:0] instr, input logic err);
        check_output({tag, "_valid"}, 32'(rsp_valid_o), 32'd1);
        check_output({tag, "_addr"},  rsp_addr_o, addr);
        check_output({tag, "_instr"}, rsp_instr_o, instr);
        check_output({tag, "_err"},   32'(rsp_err_o), 32'(err));
    endtask

    initial begin
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_addr_i   = '0;
        rsp_ready_i  = 1'b0;
        load_valid_i = 1'b0;
        load_addr_i  = '0;
        load_data_i  = '0;
        tick();
        tick();

        check_output("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check_output("rst_rsp_addr",  rsp_addr_o, 32'd0);
        check_output("rst_rsp_instr", rsp_instr_o, 32'd0);
        check_output("rst_rsp_err",   32'(rsp_err_o), 32'd0);
        check_output("rst_load_err",  32'(load_err_o), 32'd0);
        check_output("rst_req_ready", 32'(req_ready_o), 32'd1);
        rst_i = 1'b0;

        // Fill the image 00..0F.
        for (int i = 0; i < 16; i++) begin
            load_valid_i = 1'b1;
            load_addr_i  = Base + 32'(i);
            load_data_i  = 8'(i);
            tick();
            check_output("fill_load_err", 32'(load_err_o), 32'd0);
        end
        load_valid_i = 1'b0;

        // Single fetch, one cycle latency.
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h8000_0004;
        tick();
        req_valid_i = 1'b0;
        check_rsp("single", 32'h8000_0004, 32'h0706_0504, 1'b0);
        tick();
        check_output("single_drained", 32'(rsp_valid_o), 32'd0);

        // Back-to-back at full throughput.
        begin
            logic [31:0] exp_words [4];
            exp_words[0] = 32'h0302_0100;
            exp_words[1] = 32'h0706_0504;
            exp_words[2] = 32'h0B0A_0908;
            exp_words[3] = 32'h0F0E_0D0C;
            for (int i = 0; i < 4; i++) begin
                req_valid_i = 1'b1;
                req_addr_i  = Base + 32'(4 * i);
                check_output("b2b_req_ready", 32'(req_ready_o), 32'd1);
                tick();
                check_rsp("b2b", Base + 32'(4 * i), exp_words[i], 1'b0);
            end
        end
        req_valid_i = 1'b0;
        tick();
        check_output("b2b_drained", 32'(rsp_valid_o), 32'd0);

        // Backpressure: two accepted, third stalls until a slot frees.
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i  = Base;
        tick();
        check_output("bp1_req_ready", 32'(req_ready_o), 32'd1);
        check_rsp("bp1", Base, 32'h0302_0100, 1'b0);
        req_addr_i = Base + 32'd4;
        tick();
        check_output("bp2_req_ready", 32'(req_ready_o), 32'd0);
        check_rsp("bp2", Base, 32'h0302_0100, 1'b0);
        req_addr_i = Base + 32'd8;
        tick();
        check_output("bp3_req_ready", 32'(req_ready_o), 32'd0);
        check_rsp("bp3_hold", Base, 32'h0302_0100, 1'b0);
        rsp_ready_i = 1'b1;
        tick();
        check_output("bp4_req_ready", 32'(req_ready_o), 32'd1);
        check_rsp("bp4", Base + 32'd4, 32'h0706_0504, 1'b0);
        tick();
        req_valid_i = 1'b0;
        check_rsp("bp5", Base + 32'd8, 32'h0B0A_0908, 1'b0);
        tick();
        check_output("bp_drained", 32'(rsp_valid_o), 32'd0);

        // Misaligned, below base, beyond the last word.
        begin
            logic [31:0] bad_addrs [3];
            bad_addrs[0] = 32'h8000_0002;
            bad_addrs[1] = 32'h7FFF_FFFC;
            bad_addrs[2] = 32'h8000_0010;
            for (int i = 0; i < 3; i++) begin
                req_valid_i = 1'b1;
                req_addr_i  = bad_addrs[i];
                tick();
                check_rsp("err", bad_addrs[i], 32'd0, 1'b1);
            end
        end
        req_valid_i = 1'b0;
        tick();

        // Same-cycle load and fetch: fetch sees old data.
        load_valid_i = 1'b1;
        load_addr_i  = 32'h8000_0005;
        load_data_i  = 8'hAA;
        req_valid_i  = 1'b1;
        req_addr_i   = 32'h8000_0004;
        tick();
        load_valid_i = 1'b0;
        check_rsp("rbw_old", 32'h8000_0004, 32'h0706_0504, 1'b0);
        check_output("rbw_load_err", 32'(load_err_o), 32'd0);
        tick();
        req_valid_i = 1'b0;
        check_rsp("rbw_new", 32'h8000_0004, 32'h0706_AA04, 1'b0);

        // Out-of-range load pulses the error and leaves memory alone.
        load_valid_i = 1'b1;
        load_addr_i  = 32'h8000_0010;
        load_data_i  = 8'h55;
        tick();
        load_valid_i = 1'b0;
        check_output("oor_load_err_pulse", 32'(load_err_o), 32'd1);
        req_valid_i = 1'b1;
        req_addr_i  = Base;
        tick();
        req_valid_i = 1'b0;
        check_output("oor_load_err_clear", 32'(load_err_o), 32'd0);
        check_rsp("oor_mem_word0", Base, 32'h0302_0100, 1'b0);
        req_valid_i = 1'b1;
        req_addr_i  = Base + 32'd12;
        tick();
        req_valid_i = 1'b0;
        check_rsp("oor_mem_word3", Base + 32'd12, 32'h0F0E_0D0C, 1'b0);
        tick();

        // Reset with two responses queued; request and load in that cycle are ignored.
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i  = Base;
        tick();
        req_addr_i  = Base + 32'd4;
        tick();
        check_output("prerst_req_ready", 32'(req_ready_o), 32'd0);
        rst_i        = 1'b1;
        req_addr_i   = Base + 32'd8;
        load_valid_i = 1'b1;
        load_addr_i  = 32'h8000_0006;
        load_data_i  = 8'h11;
        tick();
        rst_i        = 1'b0;
        req_valid_i  = 1'b0;
        load_valid_i = 1'b0;
        check_output("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check_output("midrst_rsp_addr",  rsp_addr_o, 32'd0);
        check_output("midrst_req_ready", 32'(req_ready_o), 32'd1);
        tick();
        check_output("postrst_idle", 32'(rsp_valid_o), 32'd0);
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h8000_0004;
        tick();
        req_valid_i = 1'b0;
        check_rsp("postrst_retained", 32'h8000_0004, 32'h0706_AA04, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
